fetch_redirect_arbiter: RTL and testbench

FETCH_REDIRECT_ARBITER -- requirements
Module: fetch_redirect_arbiter

---
 rtl/fetch_redirect_arbiter_if.sv | 25 ++
 rtl/fetch_redirect_arbiter.sv | 86 ++++++++
 tb/tb_fetch_redirect_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_arbiter_if.sv
// Store/execute/exception to fetch redirect bus: three packet offers in, one slot out.
interface fetch_redirect_arbiter_if #(
  parameter int unsigned PKT_W = 64
);
  localparam int unsigned N_REQ = 3;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*PKT_W-1:0] req_data;
  logic [N_REQ-1:0]       req_accept;
  logic                   can_receive;
  logic [PKT_W-1:0]       data;
  logic                   recv;
  logic                   flush;
  logic [1:0]             grant_ptr;

  modport master (
    output req_valid, req_data, recv, flush,
    input  req_accept, can_receive, data, grant_ptr
  );

  modport slave (
    input  req_valid, req_data, recv, flush,
    output req_accept, can_receive, data, grant_ptr
  );
endinterface

// File: rtl/fetch_redirect_arbiter.sv
// Single-slot arbiter feeding fetch: exception requester has absolute priority,
// store and execute requesters share round-robin.
module fetch_redirect_arbiter #(
  parameter int unsigned PKT_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_redirect_arbiter_if.slave  bus
);
  localparam int unsigned N_REQ = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PKT_W-1:0] data_q, data_d;
  logic [1:0]       ptr_q, ptr_d;

  logic             slot_free;
  logic             capture;
  logic [1:0]       win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [PKT_W-1:0] win_data;
  logic             rr_first;

  always_comb begin
    // pointer value 2 is never produced, but is folded onto requester 0 anyway
    rr_first = (ptr_q == 2'd1);
    win_idx  = 2'd0;
    if (bus.req_valid[2]) begin
      win_idx = 2'd2;
    end else if (bus.req_valid[rr_first]) begin
      win_idx = {1'b0, rr_first};
    end else begin
      win_idx = {1'b0, ~rr_first};
    end

    slot_free = (state_q == ST_EMPTY) || bus.recv;
    capture   = (|bus.req_valid) && slot_free && !bus.flush && !reset;

    win_oh = '0;
    if (capture) begin
      win_oh[win_idx] = 1'b1;
    end

    case (win_idx)
      2'd1:    win_data = bus.req_data[PKT_W +: PKT_W];
      2'd2:    win_data = bus.req_data[2*PKT_W +: PKT_W];
      default: win_data = bus.req_data[0 +: PKT_W];
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (reset) begin
      state_d = ST_EMPTY;
      data_d  = '0;
      ptr_d   = '0;
    end else if (bus.flush) begin
      state_d = ST_EMPTY;
    end else if (capture) begin
      state_d = ST_FULL;
      data_d  = win_data;
      if (win_idx != 2'd2) begin
        ptr_d = (win_idx == 2'd0) ? 2'd1 : 2'd0;
      end
    end else if (state_q == ST_FULL && bus.recv) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    data_q  <= data_d;
    ptr_q   <= ptr_d;
  end

  assign bus.req_accept  = win_oh;
  assign bus.can_receive = (state_q == ST_FULL);
  assign bus.data        = data_q;
  assign bus.grant_ptr   = ptr_q;
endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// Directed bench for fetch_redirect_arbiter: reset, round-robin, exception priority,
// backpressure, flush and mid-operation reset.
module tb_fetch_redirect_arbiter;
  localparam int unsigned PKT_W = 64;

  logic clk;
  logic reset;
  int unsigned n_cmp;
  int unsigned n_err;

  fetch_redirect_arbiter_if #(.PKT_W(PKT_W)) bus ();

  fetch_redirect_arbiter #(.PKT_W(PKT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // apply inputs mid-cycle, then let combinational outputs settle
  task automatic drive(input logic [2:0] v, input logic rc, input logic fl, input logic rs);
    @(negedge clk);
    bus.req_valid = v;
    bus.recv      = rc;
    bus.flush     = fl;
    reset         = rs;
    #1;
  endtask

  task automatic set_data(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
    bus.req_data = {d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.recv      = 1'b0;
    bus.flush     = 1'b0;

    // reset state, with a request present that must not be accepted
    set_data(64'h55, 64'h66, 64'h77);
    drive(3'b001, 1'b1, 1'b0, 1'b1);
    check("rst_accept", bus.req_accept, 3'b000);
    tick();
    tick();
    check("rst_can_receive", bus.can_receive, 1'b0);
    check("rst_data", bus.data, 64'h0);
    check("rst_ptr", bus.grant_ptr, 2'd0);

    // single send
    set_data(64'h1234, 64'h0, 64'h0);
    drive(3'b001, 1'b0, 1'b0, 1'b0);
    check("single_accept", bus.req_accept, 3'b001);
    tick();
    check("single_can_receive", bus.can_receive, 1'b1);
    check("single_data", bus.data, 64'h1234);
    check("single_ptr", bus.grant_ptr, 2'd1);

    // drain without a new capture
    drive(3'b000, 1'b1, 1'b0, 1'b0);
    check("drain_accept", bus.req_accept, 3'b000);
    tick();
    check("drain_empty", bus.can_receive, 1'b0);

    // re-reset so the alternation starts from pointer 0
    drive(3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    check("rerst_ptr", bus.grant_ptr, 2'd0);

    // alternation with continuous consume
    set_data(64'hA0A0, 64'hB1B1, 64'h0);
    for (int i = 0; i < 4; i++) begin
      drive(3'b011, 1'b1, 1'b0, 1'b0);
      check($sformatf("alt_accept_%0d", i), bus.req_accept, (i % 2 == 0) ? 3'b001 : 3'b010);
      tick();
      check($sformatf("alt_data_%0d", i), bus.data, (i % 2 == 0) ? 64'hA0A0 : 64'hB1B1);
      check($sformatf("alt_full_%0d", i), bus.can_receive, 1'b1);
    end
    check("alt_ptr_end", bus.grant_ptr, 2'd0);

    // move pointer to 1 with a requester-0 capture
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    check("pre_exc_accept", bus.req_accept, 3'b001);
    tick();
    check("pre_exc_ptr", bus.grant_ptr, 2'd1);

    // exception wins over both round-robin requesters, pointer untouched
    set_data(64'hA0A0, 64'hB1B1, 64'hE0E0);
    drive(3'b111, 1'b1, 1'b0, 1'b0);
    check("exc_accept", bus.req_accept, 3'b100);
    tick();
    check("exc_data", bus.data, 64'hE0E0);
    check("exc_ptr", bus.grant_ptr, 2'd1);
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    check("post_exc_accept", bus.req_accept, 3'b010);
    tick();
    check("post_exc_data", bus.data, 64'hB1B1);
    check("post_exc_ptr", bus.grant_ptr, 2'd0);

    // backpressure: full slot, no consume, offer held
    set_data(64'h0, 64'hC3C3, 64'h0);
    for (int i = 0; i < 3; i++) begin
      drive(3'b010, 1'b0, 1'b0, 1'b0);
      check($sformatf("bp_accept_%0d", i), bus.req_accept, 3'b000);
      tick();
      check($sformatf("bp_data_%0d", i), bus.data, 64'hB1B1);
      check($sformatf("bp_full_%0d", i), bus.can_receive, 1'b1);
    end
    drive(3'b010, 1'b1, 1'b0, 1'b0);
    check("bp_release_accept", bus.req_accept, 3'b010);
    tick();
    check("bp_refill_data", bus.data, 64'hC3C3);
    check("bp_refill_full", bus.can_receive, 1'b1);
    check("bp_refill_ptr", bus.grant_ptr, 2'd0);

    // flush overrides recv and requests
    set_data(64'hF00D, 64'h0, 64'h0);
    drive(3'b001, 1'b1, 1'b1, 1'b0);
    check("flush_accept", bus.req_accept, 3'b000);
    tick();
    check("flush_empty", bus.can_receive, 1'b0);
    check("flush_ptr", bus.grant_ptr, 2'd0);

    // exception capture from empty
    set_data(64'h0, 64'h0, 64'hE1E1);
    drive(3'b100, 1'b0, 1'b0, 1'b0);
    check("exc_empty_accept", bus.req_accept, 3'b100);
    tick();
    check("exc_empty_data", bus.data, 64'hE1E1);
    check("exc_empty_ptr", bus.grant_ptr, 2'd0);

    // reset mid-operation discards a full slot
    set_data(64'hBEEF, 64'h0, 64'h0);
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    check("fill_accept", bus.req_accept, 3'b001);
    tick();
    check("fill_data", bus.data, 64'hBEEF);
    check("fill_ptr", bus.grant_ptr, 2'd1);
    drive(3'b001, 1'b1, 1'b0, 1'b1);
    check("midrst_accept", bus.req_accept, 3'b000);
    tick();
    check("midrst_can_receive", bus.can_receive, 1'b0);
    check("midrst_data", bus.data, 64'h0);
    check("midrst_ptr", bus.grant_ptr, 2'd0);
    drive(3'b001, 1'b0, 1'b0, 1'b0);
    check("postrst_accept", bus.req_accept, 3'b001);
    tick();
    check("postrst_data", bus.data, 64'hBEEF);
    check("postrst_full", bus.can_receive, 1'b1);

    drive(3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
